// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate truth-table sequencer: FSM states and
// reference truth tables for the two-input gate family (bit i = vector i).
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Counter width able to hold values 0..settle (it steps once past the last settle cycle).
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/gate_seq_settle_cnt.sv
// Settle-time counter: cleared while load is high, counts while en is high,
// and flags the last settle cycle of the vector currently being applied.
module gate_seq_settle_cnt
    import gate_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_width(SETTLE_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Walks every input combination of a small gate in ascending order, holds each
// for a settle time, samples the gate output and scores it against EXPECT.
module gate_truth_table_sequencer
    import gate_seq_pkg::*;
#(
    parameter int                    N_IN          = 2,
    parameter int                    SETTLE_CYCLES = 1,
    parameter logic [2**N_IN-1:0]    EXPECT        = TT_AND
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        in_vec,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2**N_IN-1:0]     fail_mask,
    output logic [2**N_IN-1:0]     captured
);

    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(2**N_IN - 1);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic            settle_tc;

    // The counter restarts on every vector because it is held clear outside APPLY.
    gate_seq_settle_cnt #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (state != APPLY),
        .en   ((state == APPLY) && !abort),
        .tc   (settle_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            in_vec    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            captured  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= APPLY;
                        idx       <= '0;
                        in_vec    <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_mask <= '0;
                        captured  <= '0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state  <= IDLE;
                        idx    <= '0;
                        in_vec <= '0;
                        busy   <= 1'b0;
                        pass   <= 1'b0;
                    end else if (settle_tc) begin
                        state <= SAMPLE;
                    end
                end
                // Abort outranks the sample, so the vector being sampled stays unscored.
                SAMPLE: begin
                    if (abort) begin
                        state  <= IDLE;
                        idx    <= '0;
                        in_vec <= '0;
                        busy   <= 1'b0;
                        pass   <= 1'b0;
                    end else begin
                        captured[idx]  <= dut_out;
                        fail_mask[idx] <= dut_out ^ EXPECT[idx];
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= APPLY;
                            idx    <= idx + 1'b1;
                            in_vec <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    idx    <= '0;
                    in_vec <= '0;
                    done   <= 1'b1;
                    pass   <= ~|fail_mask;
                end
                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    in_vec <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
